// File: rtl/point_mult_arbiter.sv
// Round-robin arbiter sharing one scalar point-multiply engine among NUM_REQ clients.
// Optional watchdog abort in RUN: define POINT_ARB_WATCHDOG_EN.
module point_mult_arbiter #(
  parameter int unsigned NUM_REQ        = 3,
  parameter int unsigned WIDTH          = 256,
  parameter int unsigned TIMEOUT_CYCLES = 1048576
) (
  input  logic                     Clk,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*WIDTH-1:0] k_in,
  input  logic [NUM_REQ*WIDTH-1:0] px_in,
  input  logic [NUM_REQ*WIDTH-1:0] py_in,
  output logic [NUM_REQ-1:0]       gnt,
  output logic [NUM_REQ-1:0]       rsp_valid,
  output logic [WIDTH-1:0]         rsp_x,
  output logic [WIDTH-1:0]         rsp_y,
  output logic                     rsp_err,
  output logic                     busy,
  output logic                     eng_reset,
  output logic [WIDTH-1:0]         eng_k,
  output logic [WIDTH-1:0]         eng_gx,
  output logic [WIDTH-1:0]         eng_gy,
  input  logic                     eng_done,
  input  logic [WIDTH-1:0]         eng_x,
  input  logic [WIDTH-1:0]         eng_y
);

  localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {IDLE, LATCH, RUN, RESP} state_t;

  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("point_mult_arbiter: illegal parameter value");
  end

  state_t               state, state_d;
  logic [IDX_W-1:0]     gidx, gidx_d;
  logic [IDX_W-1:0]     last, last_d;
  logic [NUM_REQ-1:0]   gnt_d, rsp_valid_d;
  logic [WIDTH-1:0]     rsp_x_d, rsp_y_d;
  logic [WIDTH-1:0]     eng_k_d, eng_gx_d, eng_gy_d;
  logic                 busy_d, eng_reset_d;
  logic                 win_found;
  logic [IDX_W-1:0]     win_idx;
  logic [WIDTH-1:0]     k_arr  [NUM_REQ];
  logic [WIDTH-1:0]     px_arr [NUM_REQ];
  logic [WIDTH-1:0]     py_arr [NUM_REQ];

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign k_arr[gi]  = k_in[gi*WIDTH +: WIDTH];
    assign px_arr[gi] = px_in[gi*WIDTH +: WIDTH];
    assign py_arr[gi] = py_in[gi*WIDTH +: WIDTH];
  end

  // Round-robin scan starting just after the last served client
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      if (!win_found && req[IDX_W'((32'(last) + i) % NUM_REQ)]) begin
        win_found = 1'b1;
        win_idx   = IDX_W'((32'(last) + i) % NUM_REQ);
      end
    end
  end

`ifdef POINT_ARB_WATCHDOG_EN
  logic [31:0] wd_cnt, wd_cnt_d;
  logic        rsp_err_q, rsp_err_d;
  assign rsp_err = rsp_err_q;
`else
  assign rsp_err = 1'b0;
`endif

  // Next-state and next-register values
  always_comb begin
    state_d     = state;
    gidx_d      = gidx;
    last_d      = last;
    gnt_d       = gnt;
    rsp_valid_d = '0;
    rsp_x_d     = rsp_x;
    rsp_y_d     = rsp_y;
    eng_k_d     = eng_k;
    eng_gx_d    = eng_gx;
    eng_gy_d    = eng_gy;
`ifdef POINT_ARB_WATCHDOG_EN
    wd_cnt_d    = wd_cnt;
    rsp_err_d   = rsp_err_q;
`endif
    case (state)
      IDLE: begin
        if (win_found) begin
          state_d  = LATCH;
          gidx_d   = win_idx;
          gnt_d    = NUM_REQ'(1) << win_idx;
          eng_k_d  = k_arr[win_idx];
          eng_gx_d = px_arr[win_idx];
          eng_gy_d = py_arr[win_idx];
        end
      end
      LATCH: begin
        state_d = RUN;
`ifdef POINT_ARB_WATCHDOG_EN
        wd_cnt_d = '0;
`endif
      end
      RUN: begin
`ifdef POINT_ARB_WATCHDOG_EN
        wd_cnt_d = wd_cnt + 32'd1;
`endif
        if (eng_done) begin
          state_d     = RESP;
          rsp_x_d     = eng_x;
          rsp_y_d     = eng_y;
          rsp_valid_d = gnt;
        end
`ifdef POINT_ARB_WATCHDOG_EN
        else if (wd_cnt == 32'(TIMEOUT_CYCLES - 1)) begin
          state_d     = RESP;
          rsp_x_d     = '0;
          rsp_y_d     = '0;
          rsp_valid_d = gnt;
          rsp_err_d   = 1'b1;
        end
`endif
      end
      RESP: begin
        state_d = IDLE;
        gnt_d   = '0;
        last_d  = gidx;
`ifdef POINT_ARB_WATCHDOG_EN
        rsp_err_d = 1'b0;
`endif
      end
      default: state_d = IDLE;
    endcase
    busy_d      = (state_d != IDLE);
    eng_reset_d = (state_d != RUN);
  end

  always_ff @(posedge Clk) begin
    if (reset) begin
      state     <= IDLE;
      gidx      <= '0;
      last      <= IDX_W'(NUM_REQ - 1);
      gnt       <= '0;
      rsp_valid <= '0;
      rsp_x     <= '0;
      rsp_y     <= '0;
      busy      <= 1'b0;
      eng_reset <= 1'b1;
      eng_k     <= '0;
      eng_gx    <= '0;
      eng_gy    <= '0;
    end else begin
      state     <= state_d;
      gidx      <= gidx_d;
      last      <= last_d;
      gnt       <= gnt_d;
      rsp_valid <= rsp_valid_d;
      rsp_x     <= rsp_x_d;
      rsp_y     <= rsp_y_d;
      busy      <= busy_d;
      eng_reset <= eng_reset_d;
      eng_k     <= eng_k_d;
      eng_gx    <= eng_gx_d;
      eng_gy    <= eng_gy_d;
    end
  end

`ifdef POINT_ARB_WATCHDOG_EN
  always_ff @(posedge Clk) begin
    if (reset) begin
      wd_cnt    <= '0;
      rsp_err_q <= 1'b0;
    end else begin
      wd_cnt    <= wd_cnt_d;
      rsp_err_q <= rsp_err_d;
    end
  end
`endif

endmodule

// File: tb/tb_point_mult_arbiter.sv
// Self-checking bench for point_mult_arbiter: RR service table plus corner-case sequences,
// with a behavioural engine (done 10 cycles after eng_reset falls, X = k+px, Y = k+py).
module tb_point_mult_arbiter;
  localparam int unsigned N  = 3;
  localparam int unsigned W  = 64;
  localparam int unsigned TO = 16;

  logic           Clk = 1'b0;
  logic           reset;
  logic [N-1:0]   req;
  logic [N*W-1:0] k_in, px_in, py_in;
  logic [N-1:0]   gnt, rsp_valid;
  logic [W-1:0]   rsp_x, rsp_y, eng_k, eng_gx, eng_gy, eng_x, eng_y;
  logic           rsp_err, busy, eng_reset, eng_done;

  point_mult_arbiter #(.NUM_REQ(N), .WIDTH(W), .TIMEOUT_CYCLES(TO)) dut (
    .Clk(Clk), .reset(reset), .req(req), .k_in(k_in), .px_in(px_in), .py_in(py_in),
    .gnt(gnt), .rsp_valid(rsp_valid), .rsp_x(rsp_x), .rsp_y(rsp_y), .rsp_err(rsp_err),
    .busy(busy), .eng_reset(eng_reset), .eng_k(eng_k), .eng_gx(eng_gx), .eng_gy(eng_gy),
    .eng_done(eng_done), .eng_x(eng_x), .eng_y(eng_y)
  );

  always #5 Clk = ~Clk;

  // Engine model
  logic [3:0] ecnt;
  logic       stuck = 1'b0;
  assign eng_x = eng_k + eng_gx;
  assign eng_y = eng_k + eng_gy;
  always @(posedge Clk) begin
    if (eng_reset) begin
      ecnt     <= '0;
      eng_done <= 1'b0;
    end else begin
      if (ecnt != 4'd15) ecnt <= ecnt + 4'd1;
      if (ecnt == 4'd9 && !stuck) eng_done <= 1'b1;
    end
  end

  typedef struct {
    int           client;
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic         err;
  } exp_t;

  typedef struct {
    logic [N-1:0] req;
    int           o0, o1, o2;
    int           cnt;
  } rec_t;

  exp_t sb[$];
  exp_t mon_e;
  int   total = 0;
  int   bad   = 0;
  logic mon_en = 1'b0;
  logic prev_done = 1'b0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic timeout_fail(input string name);
    total++;
    bad++;
    $display("FAIL %s: timed out (t=%0t)", name, $time);
  endtask

  function automatic logic [N-1:0] onehot(input int c);
    return N'(1) << c;
  endfunction

  function automatic logic [W-1:0] op_k(input int r, input int i);
    return W'(r * 256 + i * 16 + 1);
  endfunction
  function automatic logic [W-1:0] op_px(input int r, input int i);
    return W'(32'h1000 * (i + 1) + r);
  endfunction
  function automatic logic [W-1:0] op_py(input int r, input int i);
    return {W{1'b1}} - W'(i);
  endfunction

  task automatic set_ops(input int r);
    for (int i = 0; i < N; i++) begin
      k_in[i*W +: W]  = op_k(r, i);
      px_in[i*W +: W] = op_px(r, i);
      py_in[i*W +: W] = op_py(r, i);
    end
  endtask

  task automatic push_exp(input int r, input int c);
    sb.push_back('{client: c, x: op_k(r, c) + op_px(r, c), y: op_k(r, c) + op_py(r, c), err: 1'b0});
  endtask

  // Drop each req bit when its rsp_valid is seen, then confirm idle and drained
  task automatic wait_drain(input string name);
    for (int c = 0; c < 500 && req != '0; c++) begin
      @(negedge Clk);
      req = req & ~rsp_valid;
    end
    if (req != '0) begin
      timeout_fail(name);
      sb.delete();
    end
    req = '0;
    repeat (2) @(negedge Clk);
    chk({name, "_idle"}, W'(busy), W'(0));
    chk({name, "_drained"}, W'(sb.size()), W'(0));
  endtask

  task automatic run_rec(input rec_t rec, input int r);
    int ord[3];
    ord = '{rec.o0, rec.o1, rec.o2};
    set_ops(r);
    for (int j = 0; j < rec.cnt; j++) push_exp(r, ord[j]);
    req = rec.req;
    wait_drain($sformatf("rec%0d", r));
  endtask

  // Monitor: invariants and scoreboard pop on every response
  always @(negedge Clk) begin
    if (mon_en) begin
      chk("gnt_onehot", W'($onehot0(gnt)), W'(1));
      chk("rsp_within_gnt", W'((rsp_valid & ~gnt) == '0), W'(1));
      if (rsp_valid != '0) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_rsp: rsp_valid=%b with nothing expected (t=%0t)", rsp_valid, $time);
        end else begin
          mon_e = sb.pop_front();
          chk("rsp_client", W'(rsp_valid), W'(onehot(mon_e.client)));
          chk("rsp_x", rsp_x, mon_e.x);
          chk("rsp_y", rsp_y, mon_e.y);
          chk("rsp_err", W'(rsp_err), W'(mon_e.err));
          if (!mon_e.err) chk("rsp_after_done", W'(prev_done), W'(1));
        end
      end
      prev_done = eng_done & ~eng_reset;
    end
  end

  rec_t tbl[8];
  int   pulses;
  int   run_cyc;
  logic seen;

  initial begin
    tbl[0] = '{req: 3'b111, o0: 0, o1: 1, o2: 2, cnt: 3};
    tbl[1] = '{req: 3'b010, o0: 1, o1: 0, o2: 0, cnt: 1};
    tbl[2] = '{req: 3'b101, o0: 2, o1: 0, o2: 0, cnt: 2};
    tbl[3] = '{req: 3'b110, o0: 1, o1: 2, o2: 0, cnt: 2};
    tbl[4] = '{req: 3'b011, o0: 0, o1: 1, o2: 0, cnt: 2};
    tbl[5] = '{req: 3'b111, o0: 2, o1: 0, o2: 1, cnt: 3};
    tbl[6] = '{req: 3'b001, o0: 0, o1: 0, o2: 0, cnt: 1};
    tbl[7] = '{req: 3'b011, o0: 1, o1: 0, o2: 0, cnt: 2};

    reset = 1'b1;
    req   = '0;
    k_in  = '0;
    px_in = '0;
    py_in = '0;
    repeat (3) @(negedge Clk);
    chk("rst_gnt", W'(gnt), W'(0));
    chk("rst_rsp_valid", W'(rsp_valid), W'(0));
    chk("rst_rsp_x", rsp_x, W'(0));
    chk("rst_rsp_y", rsp_y, W'(0));
    chk("rst_rsp_err", W'(rsp_err), W'(0));
    chk("rst_busy", W'(busy), W'(0));
    chk("rst_eng_reset", W'(eng_reset), W'(1));
    chk("rst_eng_k", eng_k, W'(0));
    chk("rst_eng_gx", eng_gx, W'(0));
    chk("rst_eng_gy", eng_gy, W'(0));
    reset  = 1'b0;
    mon_en = 1'b1;

    for (int r = 0; r < 8; r++) run_rec(tbl[r], r);

    // Single client with fixed operands and grant/engine-reset latency
    set_ops(8);
    k_in[1*W +: W]  = W'(5);
    px_in[1*W +: W] = W'(32'h10);
    py_in[1*W +: W] = W'(32'h20);
    sb.push_back('{client: 1, x: W'(32'h15), y: W'(32'h25), err: 1'b0});
    req = 3'b010;
    @(negedge Clk);
    chk("single_gnt", W'(gnt), W'(3'b010));
    chk("single_latch_eng_reset", W'(eng_reset), W'(1));
    chk("single_busy", W'(busy), W'(1));
    chk("single_eng_k", eng_k, W'(5));
    chk("single_eng_gx", eng_gx, W'(32'h10));
    @(negedge Clk);
    chk("single_run_eng_reset", W'(eng_reset), W'(0));
    wait_drain("single");

    // Request withdrawn 3 cycles after grant still completes exactly once
    set_ops(9);
    push_exp(9, 2);
    req  = 3'b100;
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge Clk);
      seen = (gnt != '0);
    end
    if (!seen) timeout_fail("withdraw_gnt");
    chk("withdraw_gnt", W'(gnt), W'(3'b100));
    repeat (3) @(negedge Clk);
    req = '0;
    pulses = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge Clk);
      if (rsp_valid[2]) pulses++;
    end
    chk("withdraw_pulses", W'(pulses), W'(1));
    chk("withdraw_drained", W'(sb.size()), W'(0));
    sb.delete();

    // Reset at cycle 5 of RUN aborts without a response
    set_ops(10);
    req  = 3'b001;
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge Clk);
      seen = !eng_reset;
    end
    if (!seen) timeout_fail("midrst_run");
    repeat (4) @(negedge Clk);
    reset = 1'b1;
    req   = '0;
    @(negedge Clk);
    chk("midrst_gnt", W'(gnt), W'(0));
    chk("midrst_eng_reset", W'(eng_reset), W'(1));
    chk("midrst_rsp_valid", W'(rsp_valid), W'(0));
    chk("midrst_busy", W'(busy), W'(0));
    reset = 1'b0;
    repeat (15) @(negedge Clk);
    run_rec('{req: 3'b001, o0: 0, o1: 0, o2: 0, cnt: 1}, 11);

`ifdef POINT_ARB_WATCHDOG_EN
    // Engine never finishes: abort with error after TO cycles in RUN
    stuck = 1'b1;
    set_ops(12);
    sb.push_back('{client: 0, x: W'(0), y: W'(0), err: 1'b1});
    req     = 3'b001;
    run_cyc = 0;
    seen    = 1'b0;
    for (int c = 0; c < 100 && !seen; c++) begin
      @(negedge Clk);
      if (rsp_valid != '0) seen = 1'b1;
      else if (!eng_reset) run_cyc++;
    end
    if (!seen) timeout_fail("wd_rsp");
    chk("wd_run_cycles", W'(run_cyc), W'(TO));
    req = '0;
    repeat (2) @(negedge Clk);
    chk("wd_err_cleared", W'(rsp_err), W'(0));
    stuck = 1'b0;
    run_rec('{req: 3'b010, o0: 1, o1: 0, o2: 0, cnt: 1}, 13);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
